// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the MAC TX AXI-Stream port.
// A grant is held from the first beat through tlast; mid-frame stalls are flagged.
module mac_tx_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned N_SYMBOLS = 4,
  parameter int unsigned W_SYMBOL  = 8,
  parameter int unsigned W_SRC     = $clog2(N_SRC)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_clk_en,
  input  logic [N_SRC-1:0]                      i_src_en,
  input  logic [N_SRC-1:0]                      s_axis_tvalid,
  input  logic [N_SRC*N_SYMBOLS-1:0]            s_axis_tkeep,
  input  logic [N_SRC*N_SYMBOLS*W_SYMBOL-1:0]   s_axis_tdata,
  input  logic [N_SRC-1:0]                      s_axis_tlast,
  output logic [N_SRC-1:0]                      s_axis_tready,
  output logic                                  m_axis_tvalid,
  output logic [N_SYMBOLS-1:0]                  m_axis_tkeep,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]         m_axis_tdata,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [N_SRC-1:0]                      o_grant,
  output logic                                  o_busy,
  output logic                                  o_frame_done,
  output logic [W_SRC-1:0]                      o_frame_src,
  output logic                                  o_stall_err
);

  localparam int unsigned WBeat = N_SYMBOLS * W_SYMBOL;

  typedef enum logic [0:0] {StIdle, StPass} state_e;

  state_e           state_q, state_d;
  logic [W_SRC-1:0] grant_idx_q, grant_idx_d;
  logic [W_SRC-1:0] last_idx_q, last_idx_d;
  logic             first_q, first_d;

  logic [N_SRC-1:0] req;
  logic [W_SRC-1:0] pick_idx;
  logic             pick_found;
  logic             hs;

  assign req = s_axis_tvalid & i_src_en;

  // Cyclic search starting just after the last source that completed a frame.
  always_comb begin
    int unsigned      cand;
    logic [W_SRC-1:0] cand_w;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand   = (32'(last_idx_q) + 32'd1 + k) % N_SRC;
      cand_w = W_SRC'(cand);
      if (!pick_found && req[cand_w]) begin
        pick_found = 1'b1;
        pick_idx   = cand_w;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    last_idx_d    = last_idx_q;
    first_d       = first_q;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tkeep  = '0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    o_grant       = '0;
    o_busy        = 1'b0;
    o_frame_done  = 1'b0;
    o_frame_src   = '0;
    o_stall_err   = 1'b0;
    hs            = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_clk_en && pick_found) begin
          grant_idx_d = pick_idx;
          first_d     = 1'b1;
          state_d     = StPass;
        end
      end
      StPass: begin
        o_busy = 1'b1;
        for (int unsigned i = 0; i < N_SRC; i++) begin
          if (grant_idx_q == W_SRC'(i)) begin
            m_axis_tvalid    = s_axis_tvalid[i];
            m_axis_tkeep     = s_axis_tkeep[i*N_SYMBOLS +: N_SYMBOLS];
            m_axis_tdata     = s_axis_tdata[i*WBeat +: WBeat];
            m_axis_tlast     = s_axis_tlast[i];
            s_axis_tready[i] = m_axis_tready;
            o_grant[i]       = 1'b1;
          end
        end
        hs = m_axis_tvalid & m_axis_tready & i_clk_en;
        if (hs) begin
          first_d = 1'b0;
        end
        if (hs && m_axis_tlast) begin
          o_frame_done = 1'b1;
          o_frame_src  = grant_idx_q;
          last_idx_d   = grant_idx_q;
          state_d      = StIdle;
        end
        // The MAC cannot pause mid-frame, so a bubble after the first beat is an error.
        if (!first_q && !m_axis_tvalid && m_axis_tready && i_clk_en) begin
          o_stall_err = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      last_idx_q  <= W_SRC'(N_SRC - 1);
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      first_q     <= first_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed self-checking bench for mac_tx_arbiter (4 sources, 32-bit beats).
module tb_mac_tx_arbiter;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_clk_en = 1'b1;
  logic [3:0]   i_src_en = 4'hF;
  logic [3:0]   s_axis_tvalid = '0;
  logic [15:0]  s_axis_tkeep = '0;
  logic [127:0] s_axis_tdata = '0;
  logic [3:0]   s_axis_tlast = '0;
  logic [3:0]   s_axis_tready;
  logic         m_axis_tvalid;
  logic [3:0]   m_axis_tkeep;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic [3:0]   o_grant;
  logic         o_busy;
  logic         o_frame_done;
  logic [1:0]   o_frame_src;
  logic         o_stall_err;

  int checks = 0;
  int errors = 0;

  mac_tx_arbiter dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clk_en      (i_clk_en),
    .i_src_en      (i_src_en),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_grant       (o_grant),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_frame_src   (o_frame_src),
    .o_stall_err   (o_stall_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int unsigned idx, input logic v, input logic [3:0] k,
                       input logic [31:0] d, input logic l);
    s_axis_tvalid[idx]        = v;
    s_axis_tkeep[idx*4 +: 4]  = k;
    s_axis_tdata[idx*32 +: 32] = d;
    s_axis_tlast[idx]         = l;
  endtask

  task automatic do_reset();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    i_src_en      = 4'hF;
    i_clk_en      = 1'b1;
    m_axis_tready = 1'b1;
    i_reset       = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    drive(0, 1'b1, 4'hF, 32'h1111_1111, 1'b0);
    #2;
    checks++;
    if (o_grant !== 4'b0 || o_busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b busy=%b mvalid=%b, required 0000 0 0",
               o_grant, o_busy, m_axis_tvalid);
    end
    checks++;
    if (s_axis_tready !== 4'b0 || o_frame_done !== 1'b0 || o_stall_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: tready=%b done=%b stall=%b, required 0000 0 0",
               s_axis_tready, o_frame_done, o_stall_err);
    end
    do_reset();
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic [3:0]  k;
    do_reset();
    drive(2, 1'b1, 4'hF, 32'hA0B0_C0D0, 1'b0);
    #1;
    checks++;
    if (o_grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_pre_grant: grant=%b, required 0000", o_grant);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      d = 32'hA0B0_C0D0 + 32'(b);
      k = (b == 3) ? 4'h3 : 4'hF;
      drive(2, 1'b1, k, d, b == 3);
      #1;
      checks++;
      if (o_grant !== 4'b0100 || s_axis_tready !== 4'b0100) begin
        errors++;
        $display("FAIL single_grant beat %0d: grant=%b tready=%b, required 0100 0100",
                 b, o_grant, s_axis_tready);
      end
      checks++;
      if (m_axis_tdata !== d || m_axis_tkeep !== k || m_axis_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL single_data beat %0d: data=%h keep=%h valid=%b, required %h %h 1",
                 b, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, d, k);
      end
      checks++;
      if (o_frame_done !== (b == 3) || m_axis_tlast !== (b == 3) ||
          (b == 3 && o_frame_src !== 2'd2)) begin
        errors++;
        $display("FAIL single_done beat %0d: done=%b last=%b src=%0d, required %b %b 2",
                 b, o_frame_done, m_axis_tlast, o_frame_src, b == 3, b == 3);
      end
      tick();
    end
    drive(2, 1'b0, 4'h0, 32'h0, 1'b0);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle_after: busy=%b grant=%b, required 0 0000", o_busy, o_grant);
    end
  endtask

  task automatic run_order(input string name, input logic [3:0] en, input int nframes,
                           input int order[8]);
    do_reset();
    i_src_en = en;
    for (int s = 0; s < 4; s++) drive(s, 1'b1, 4'hF, 32'hC0DE_0000 + 32'(s), 1'b1);
    for (int f = 0; f < nframes; f++) begin
      #1;
      checks++;
      if (o_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_gap frame %0d: busy=%b, required 0", name, f, o_busy);
      end
      tick();
      checks++;
      if (o_grant !== (4'b1 << order[f]) || o_frame_done !== 1'b1 ||
          o_frame_src !== 2'(order[f])) begin
        errors++;
        $display("FAIL %s_grant frame %0d: grant=%b done=%b src=%0d, required %b 1 %0d",
                 name, f, o_grant, o_frame_done, o_frame_src, 4'b1 << order[f], order[f]);
      end
      tick();
    end
    s_axis_tvalid = '0;
    i_src_en = 4'hF;
  endtask

  task automatic test_round_robin();
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_order("rr", 4'b1111, 8, order);
  endtask

  task automatic test_src_en();
    int order[8] = '{0, 1, 3, 0, 0, 0, 0, 0};
    run_order("src_en", 4'b1011, 4, order);
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 1'b1, 4'hF, 32'h5000_0000, 1'b0);
    tick();
    #1;
    checks++;
    if (o_grant !== 4'b0010 || o_stall_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_beat0: grant=%b stall=%b, required 0010 0", o_grant, o_stall_err);
    end
    tick();
    drive(1, 1'b1, 4'hF, 32'h5000_0001, 1'b0);
    tick();
    drive(1, 1'b0, 4'hF, 32'h5000_0002, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (o_stall_err !== 1'b1 || o_grant !== 4'b0010 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_pulse cycle %0d: stall=%b grant=%b busy=%b, required 1 0010 1",
                 c, o_stall_err, o_grant, o_busy);
      end
      tick();
    end
    drive(1, 1'b1, 4'hF, 32'h5000_0002, 1'b0);
    #1;
    checks++;
    if (o_stall_err !== 1'b0 || m_axis_tdata !== 32'h5000_0002) begin
      errors++;
      $display("FAIL stall_resume: stall=%b data=%h, required 0 50000002",
               o_stall_err, m_axis_tdata);
    end
    tick();
    drive(1, 1'b1, 4'h3, 32'h5000_0003, 1'b1);
    #1;
    checks++;
    if (o_frame_done !== 1'b1 || o_frame_src !== 2'd1) begin
      errors++;
      $display("FAIL stall_done: done=%b src=%0d, required 1 1", o_frame_done, o_frame_src);
    end
    tick();
    drive(1, 1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic test_clk_en();
    do_reset();
    drive(3, 1'b1, 4'hF, 32'h7700_0000, 1'b0);
    tick();
    tick();
    drive(3, 1'b1, 4'h1, 32'h7700_0001, 1'b1);
    i_clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (o_frame_done !== 1'b0 || o_busy !== 1'b1 || o_grant !== 4'b1000 ||
          m_axis_tdata !== 32'h7700_0001) begin
        errors++;
        $display("FAIL clk_en_frozen cycle %0d: done=%b busy=%b grant=%b data=%h, req 0 1 1000",
                 c, o_frame_done, o_busy, o_grant, m_axis_tdata);
      end
      tick();
    end
    i_clk_en = 1'b1;
    #1;
    checks++;
    if (o_frame_done !== 1'b1 || o_frame_src !== 2'd3) begin
      errors++;
      $display("FAIL clk_en_resume: done=%b src=%0d, required 1 3", o_frame_done, o_frame_src);
    end
    tick();
    drive(3, 1'b0, 4'h0, 32'h0, 1'b0);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL clk_en_idle: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    drive(1, 1'b1, 4'hF, 32'h9000_0000, 1'b0);
    tick();
    tick();
    tick();
    tick();
    #2;
    i_reset = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 4'b0 || o_grant !== 4'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: tready=%b grant=%b mvalid=%b, required 0000 0000 0",
               s_axis_tready, o_grant, m_axis_tvalid);
    end
    for (int s = 0; s < 4; s++) drive(s, 1'b1, 4'hF, 32'hB000_0000 + 32'(s), 1'b1);
    tick();
    i_reset = 1'b0;
    tick();
    checks++;
    if (o_grant !== 4'b0001 || m_axis_tdata !== 32'hB000_0000) begin
      errors++;
      $display("FAIL reset_mid_first: grant=%b data=%h, required 0001 b0000000",
               o_grant, m_axis_tdata);
    end
    s_axis_tvalid = '0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_src_en();
    test_stall();
    test_clk_en();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Frame-level round-robin arbiter that shares the single AXI-Stream slave port of the MAC TX controller between `N_SRC` upstream frame sources. Once a source is granted, the grant is held for a whole frame, from the first beat to the `tlast` beat, so frames never interleave. The block sits directly in front of `mac_tx_ctrl`. It also flags sources that stall mid-frame, because the MAC cannot tolerate a paused frame.

## Interface
- `N_SRC`, 4: number of requesting sources, 2..8.
- `N_SYMBOLS`, 4: bytes per beat.
- `W_SYMBOL`, 8: bits per byte.
- `W_SRC`, `$clog2(N_SRC)`: width of source index (derived).

Ports:
- `i_clk`, in, 1: clock; single clock domain.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_clk_en`, in, 1: clock enable; all state advances only when high.
- `i_src_en`, in, `N_SRC`: per-source enable mask; a disabled source is never newly granted.
- `s_axis_tvalid`, in, `N_SRC`: per-source valid.
- `s_axis_tkeep`, in, `N_SRC`×`N_SYMBOLS`: per-source byte keep.
- `s_axis_tdata`, in, `N_SRC`×`N_SYMBOLS`×`W_SYMBOL`: per-source data.
- `s_axis_tlast`, in, `N_SRC`: per-source end of frame.
- `s_axis_tready`, out, `N_SRC`: per-source ready.
- `m_axis_tvalid`, out, 1: valid toward the MAC.
- `m_axis_tkeep`, out, `N_SYMBOLS`: keep toward the MAC.
- `m_axis_tdata`, out, `N_SYMBOLS`×`W_SYMBOL`: data toward the MAC.
- `m_axis_tlast`, out, 1: end of frame toward the MAC.
- `m_axis_tready`, in, 1: ready from the MAC (already clock-enable gated).
- `o_grant`, out, `N_SRC`: one-hot current grant; all zero when idle.
- `o_busy`, out, 1: high while in `ST_PASS`.
- `o_frame_done`, out, 1: one-cycle pulse on the accepted `tlast` beat.
- `o_frame_src`, out, `W_SRC`: source index of the completed frame; valid with `o_frame_done`.
- `o_stall_err`, out, 1: one-cycle pulse when the granted source drops `tvalid` mid-frame while `m_axis_tready` is high.

## Operation
- Beat handshake (`hs`) = `m_axis_tvalid & m_axis_tready & i_clk_en`.
- Registered state:
  - `q_state` ∈ {`ST_IDLE`, `ST_PASS`}.
  - `q_grant_idx` (`W_SRC` bits).
  - `q_last_idx` (`W_SRC` bits).
  - `q_first` (1 bit): no beat of the current frame accepted yet.
- `ST_IDLE`:
  - All `s_axis_tready` = 0; `m_axis_tvalid` = 0.
  - Request vector `req` = `s_axis_tvalid & i_src_en`.
  - If `req` ≠ 0 and `i_clk_en` is high: pick the first set bit, searching cyclically from `q_last_idx+1` (mod `N_SRC`) upward; load it into `q_grant_idx`; set `q_first` = 1; go to `ST_PASS`.
- `ST_PASS`:
  - `m_axis_*` = `s_axis_*[q_grant_idx]`, combinational mux.
  - `s_axis_tready[q_grant_idx]` = `m_axis_tready`; all other readies = 0.
  - On `hs`: clear `q_first`.
  - On `hs & m_axis_tlast`: pulse `o_frame_done`; set `o_frame_src` = `q_grant_idx`; `q_last_idx` ← `q_grant_idx`; go to `ST_IDLE`.
- Stall check: in `ST_PASS`, if `!q_first & !m_axis_tvalid & m_axis_tready & i_clk_en`, pulse `o_stall_err`. The grant is kept and the state is unchanged.
- Changing `i_src_en` for the granted source mid-frame has no effect on the current frame.
- A source that drops `tvalid` while in `ST_IDLE` simply loses arbitration. Nothing is latched.
- `tkeep`/`tdata` are forwarded unmodified. Alignment checking belongs to the MAC.

## Timing
- Reset values:
  - `q_state` = `ST_IDLE`.
  - `q_last_idx` = `N_SRC-1`, so source 0 wins the first arbitration.
  - `q_grant_idx` = 0; `q_first` = 0.
  - All outputs 0.
- Arbitration latency: a request seen in `ST_IDLE` gives a grant and `m_axis_tvalid` on the next enabled cycle.
- Minimum gap between frames: one `ST_IDLE` cycle after every `tlast` beat, even when requests are pending. This is harmless because the MAC holds `tready` low through its IFG.
- When `i_clk_en` is low, state and outputs `o_frame_done`/`o_stall_err` are frozen or zero.
- Reset asserted mid-frame: state goes to `ST_IDLE` immediately and asynchronously; all readies drop to 0; the partial frame is abandoned.
- Round-robin wrap: after source `N_SRC-1`, the search restarts at 0.
- Fairness: each source waits at most `N_SRC-1` frames.

## Test plan
- Single source 2, one frame of 4 beats with `tkeep` = `F` then `tlast` with `tkeep` = `3` → `o_grant` = `4'b0100` one cycle after the request; 4 beats pass unchanged; `o_frame_done` = 1 and `o_frame_src` = 2 on the last beat; `ST_IDLE` on the next cycle.
- After reset, sources 0..3 all requesting continuously for 8 frames → grant order 0,1,2,3,0,1,2,3; exactly one idle cycle between frames.
- `i_src_en` = `4'b1011` with all sources requesting → source 2 is never granted; order 0,1,3,0.
- Granted source drops `tvalid` for 2 cycles on beat 2 while `m_axis_tready` = 1 → two `o_stall_err` pulses; grant is held; the frame completes afterwards.
- Hold `i_clk_en` low for 3 cycles mid-frame → no beats accepted and no state change; transfer resumes unchanged.
- Assert `i_reset` on beat 3 of a frame → all readies 0 and `o_grant` = 0 immediately; after release, source 0 wins first.
